csr_bank: RTL and testbench
===========================

// Module: csr_bank
// PURPOSE
//   Parametrised CSR bank bridging an asynchronous host port (SPI/GPIO-driven strobes) to clk_i.
//   Holds NUM_CONFIG_REG config registers with per-register reset values.
//   Config bits are plain RW or self-clearing pulse (command) bits.
//   Status bits are live or sticky (write-1-to-clear); any sticky bit set drives irq_o.
//   Sits between the host interface block and the datapath config/status buses.
// PARAMETERS
//   ADDR_WIDTH      7       address width; config at 0..NUM_CONFIG_REG-1, status follows
//   DATA_WIDTH      8       register width
//   NUM_CONFIG_REG  12      number of RW config registers
//   NUM_STATUS_REG  4       number of status registers
//   SYNC_STAGES     2       synchroniser depth for write_en_i/read_en_i (>=2)
//   CFG_RESET       {..,8'hCC}  packed DATA_WIDTH*NUM_CONFIG_REG reset values; reg0=8'hCC, others 0
//   CFG_PULSE_MASK  0       packed per-bit mask; 1 = bit self-clears to its reset value 1 cycle after write
//   STS_STICKY_MASK 0       packed DATA_WIDTH*NUM_STATUS_REG mask; 1 = bit latches high, W1C
// PORTS
//   clk_i         in   1                      clock
//   rst_n         in   1                      reset, synchronous, active-low
//   addr_i        in   ADDR_WIDTH             register address; stable while a strobe is high
//   write_data_i  in   DATA_WIDTH             write data; stable while write_en_i is high
//   write_en_i    in   1                      async write strobe; rising edge = one write
//   read_en_i     in   1                      async read strobe; rising edge = one read
//   read_data_o   out  DATA_WIDTH             read result, held until next read
//   read_valid_o  out  1                      1-cycle pulse when read_data_o updates
//   error_o       out  1                      1-cycle pulse on out-of-range access
//   irq_o         out  1                      OR of all sticky status bits
//   config_bus_o  out  DATA_WIDTH*NUM_CONFIG_REG   reg i at [DATA_WIDTH*(i+1)-1:DATA_WIDTH*i]
//   status_bus_i  in   DATA_WIDTH*NUM_STATUS_REG   live status inputs, same packing
// BEHAVIOUR
//   Reset: config regs = CFG_RESET; sticky bits = 0.
//     read_data_o=0, read_valid_o=0, error_o=0, irq_o=0; FSM -> IDLE.
//     Sync chains reset to all-ones, so a strobe held high across reset release gives no edge.
//   Edge detect: rise = sync[last]==1 && prev==0.
//     Commit latency: SYNC_STAGES+1 clk_i cycles from strobe rise to detected edge.
//   FSM IDLE/WRITE/READ/ERR:
//     IDLE->WRITE on write edge; IDLE->READ on read edge; IDLE->ERR if addr out of range.
//     All states return to IDLE after 1 cycle.
//     Simultaneous write+read edges: write first; read latched pending and served next cycle.
//   WRITE, addr<NUM_CONFIG_REG: reg <= write_data_i.
//     Pulse bits revert to reset value on the following cycle.
//   WRITE, status addr: sticky bits with data=1 clear; live bits ignore writes.
//     Set and clear of the same sticky bit in one cycle: set wins.
//   READ: read_data_o <= config reg, or status value (live | sticky), in the same cycle.
//     read_valid_o pulses the next cycle.
//   ERR: addr >= NUM_CONFIG_REG+NUM_STATUS_REG.
//     Writes are dropped; reads return all-ones with read_valid_o; error_o pulses in both cases.
//   Sticky capture: sticky |= status_bus_i & STS_STICKY_MASK every cycle; irq_o registered (1-cycle lag).
//   Reset mid-operation aborts the pending write/read; no partial commit.
// STRUCTURE
//   csr_pkg: FSM state enum, csr_access_t {addr,data,is_write}, default reset helper constants.
//   Sub-module sync_edge_detect #(SYNC_STAGES): synchroniser + rise detect, instanced for write and read.
//   Register file, sticky logic and FSM stay in csr_bank.
// TESTING
//   Reset release -> config_bus_o[7:0]=8'hCC, others 0; read addr 0 -> read_data_o=8'hCC, read_valid_o 1 cycle.
//   Write 8'h5A to addr 3 -> config reg3=8'h5A exactly SYNC_STAGES+1 cycles after strobe; strobe held 10 cycles -> one write only.
//   CFG_PULSE_MASK reg2=8'h01, write 8'h01 -> bit0 high one cycle, then 0; readback 8'h00.
//   STS_STICKY reg0 bit3: pulse status bit3 one cycle -> irq_o=1, read addr12 -> 8'h08; write 8'h08 to addr12 -> cleared, irq_o=0.
//   Read addr 16 -> read_data_o=8'hFF, error_o pulse; write addr 20 -> no config change, error_o pulse.
//   Write+read strobes in the same cycle (addr 5) -> read returns the newly written data; rst_n low mid-sync -> no commit.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared types and default constants for the CSR bank: FSM states, the
// per-access descriptor, and the reset helper values.
package csr_pkg;

  localparam int CSR_ADDR_MAX_W = 16;
  localparam int CSR_DATA_MAX_W = 32;

  localparam logic [7:0] CSR_REG0_RESET = 8'hCC;
  localparam logic [7:0] CSR_ERR_FILL   = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_ERR
  } csr_state_e;

  typedef struct packed {
    logic [CSR_ADDR_MAX_W-1:0] addr;
    logic [CSR_DATA_MAX_W-1:0] data;
    logic                      is_write;
  } csr_access_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for an asynchronous strobe plus rising-edge detect.
// The chain resets to ones so a strobe held high through reset gives no edge.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n,
  input  logic async_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/csr_bank.sv
// CSR bank bridging an asynchronous host strobe port to clk_i: config
// registers with RW/pulse bits, status registers with live/sticky W1C bits.
module csr_bank
  import csr_pkg::*;
#(
  parameter int ADDR_WIDTH     = 7,
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_CONFIG_REG = 12,
  parameter int NUM_STATUS_REG = 4,
  parameter int SYNC_STAGES    = 2,
  parameter logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] CFG_RESET =
    {{(DATA_WIDTH*(NUM_CONFIG_REG-1)){1'b0}}, DATA_WIDTH'(CSR_REG0_RESET)},
  parameter logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] CFG_PULSE_MASK  = '0,
  parameter logic [DATA_WIDTH*NUM_STATUS_REG-1:0] STS_STICKY_MASK = '0
) (
  input  logic                                 clk_i,
  input  logic                                 rst_n,
  input  logic [ADDR_WIDTH-1:0]                addr_i,
  input  logic [DATA_WIDTH-1:0]                write_data_i,
  input  logic                                 write_en_i,
  input  logic                                 read_en_i,
  output logic [DATA_WIDTH-1:0]                read_data_o,
  output logic                                 read_valid_o,
  output logic                                 error_o,
  output logic                                 irq_o,
  output logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] config_bus_o,
  input  logic [DATA_WIDTH*NUM_STATUS_REG-1:0] status_bus_i
);

  localparam int NUM_REG = NUM_CONFIG_REG + NUM_STATUS_REG;

  logic wr_rise, rd_rise, rd_pend_q;
  logic acc_valid, acc_oor, wr_cfg, wr_sts, rd_take;
  int   acc_idx;

  csr_state_e  state_q, state_d;
  csr_access_t acc;

  logic [DATA_WIDTH-1:0]                wdata, rd_val;
  logic [DATA_WIDTH*NUM_CONFIG_REG-1:0] cfg_q, cfg_d;
  logic [DATA_WIDTH*NUM_STATUS_REG-1:0] sts_q, sts_d, sts_clr, sts_view;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_wr_edge (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .async_i (write_en_i),
    .rise_o  (wr_rise)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_rd_edge (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .async_i (read_en_i),
    .rise_o  (rd_rise)
  );

  // Write wins a tie; the read waits one cycle in rd_pend_q and then sees the new data.
  always_comb begin
    acc          = '0;
    acc.addr     = CSR_ADDR_MAX_W'(addr_i);
    acc.data     = CSR_DATA_MAX_W'(write_data_i);
    acc.is_write = wr_rise;
    acc_valid    = wr_rise | rd_rise | rd_pend_q;
    acc_idx      = int'(acc.addr);
    acc_oor      = acc_idx >= NUM_REG;
    state_d      = ST_IDLE;
    if (acc_valid) begin
      if (acc_oor)           state_d = ST_ERR;
      else if (acc.is_write) state_d = ST_WRITE;
      else                   state_d = ST_READ;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rd_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= wr_rise & (rd_rise | rd_pend_q);
    end
  end

  assign wdata    = DATA_WIDTH'(acc.data);
  assign wr_cfg   = (state_d == ST_WRITE) && (acc_idx < NUM_CONFIG_REG);
  assign wr_sts   = (state_d == ST_WRITE) && (acc_idx >= NUM_CONFIG_REG);
  assign rd_take  = (state_d == ST_READ) || ((state_d == ST_ERR) && !acc.is_write);
  assign sts_view = status_bus_i | sts_q;

  always_comb begin
    cfg_d   = (cfg_q & ~CFG_PULSE_MASK) | (CFG_RESET & CFG_PULSE_MASK);
    sts_clr = '0;
    rd_val  = '1;
    for (int i = 0; i < NUM_CONFIG_REG; i++) begin
      if (acc_idx == i) begin
        rd_val = cfg_q[DATA_WIDTH*i +: DATA_WIDTH];
        if (wr_cfg) cfg_d[DATA_WIDTH*i +: DATA_WIDTH] = wdata;
      end
    end
    for (int j = 0; j < NUM_STATUS_REG; j++) begin
      if (acc_idx == NUM_CONFIG_REG + j) begin
        rd_val = sts_view[DATA_WIDTH*j +: DATA_WIDTH];
        if (wr_sts) sts_clr[DATA_WIDTH*j +: DATA_WIDTH] =
          wdata & STS_STICKY_MASK[DATA_WIDTH*j +: DATA_WIDTH];
      end
    end
    // New events override a same-cycle clear.
    sts_d = (sts_q & ~sts_clr) | (status_bus_i & STS_STICKY_MASK);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      cfg_q        <= CFG_RESET;
      sts_q        <= '0;
      irq_o        <= 1'b0;
      read_data_o  <= '0;
      read_valid_o <= 1'b0;
    end else begin
      cfg_q        <= cfg_d;
      sts_q        <= sts_d;
      irq_o        <= |sts_q;
      read_valid_o <= rd_take;
      if (rd_take) read_data_o <= rd_val;
    end
  end

  assign error_o      = (state_q == ST_ERR);
  assign config_bus_o = cfg_q;

endmodule

// File: tb/tb_csr_bank.sv
// Directed bench for csr_bank: reset values, strobe-to-commit latency,
// pulse and sticky bits, out-of-range accesses, write/read collision, reset abort.
module tb_csr_bank;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  addr_i = '0;
  logic [7:0]  write_data_i = '0;
  logic        write_en_i = 1'b0;
  logic        read_en_i = 1'b0;
  logic [7:0]  read_data_o;
  logic        read_valid_o;
  logic        error_o;
  logic        irq_o;
  logic [95:0] config_bus_o;
  logic [31:0] status_bus_i = '0;

  int n_chk  = 0;
  int n_pass = 0;

  logic [95:0] exp_bus;
  logic [7:0]  rdata;
  logic        rerr;
  int          errs;
  int          hi_cnt;

  csr_bank #(
    .CFG_PULSE_MASK  (96'h0000_0000_0000_0000_0001_0000),
    .STS_STICKY_MASK (32'h0000_0008)
  ) dut (
    .clk_i        (clk_i),
    .rst_n        (rst_n),
    .addr_i       (addr_i),
    .write_data_i (write_data_i),
    .write_en_i   (write_en_i),
    .read_en_i    (read_en_i),
    .read_data_o  (read_data_o),
    .read_valid_o (read_valid_o),
    .error_o      (error_o),
    .irq_o        (irq_o),
    .config_bus_o (config_bus_o),
    .status_bus_i (status_bus_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic do_write(input logic [6:0] a, input logic [7:0] d, output int err_cycles);
    addr_i       = a;
    write_data_i = d;
    write_en_i   = 1'b1;
    err_cycles   = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i);
      #1;
      if (error_o) err_cycles++;
      if (i == 3) write_en_i = 1'b0;
    end
  endtask

  task automatic do_read(input string tag, input logic [6:0] a, input logic both,
                         input logic [7:0] wd, output logic [7:0] d, output logic e);
    logic seen;
    seen         = 1'b0;
    d            = '0;
    e            = 1'b0;
    addr_i       = a;
    write_data_i = wd;
    read_en_i    = 1'b1;
    write_en_i   = both;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk_i);
      #1;
      if (read_valid_o) begin
        seen = 1'b1;
        d    = read_data_o;
        e    = error_o;
      end
    end
    chk({tag, "_valid_seen"}, 96'(seen), 96'd1);
    tick(1);
    chk({tag, "_valid_1cyc"}, 96'(read_valid_o), 96'd0);
    read_en_i  = 1'b0;
    write_en_i = 1'b0;
    tick(5);
  endtask

  initial begin
    exp_bus = 96'hCC;
    tick(3);
    rst_n = 1'b1;
    tick(5);
    chk("rst_cfg_bus", config_bus_o, exp_bus);
    chk("rst_rdata", 96'(read_data_o), 96'h0);
    chk("rst_rvalid", 96'(read_valid_o), 96'h0);
    chk("rst_error", 96'(error_o), 96'h0);
    chk("rst_irq", 96'(irq_o), 96'h0);

    do_read("rd0", 7'd0, 1'b0, 8'h00, rdata, rerr);
    chk("rd0_data", 96'(rdata), 96'hCC);
    chk("rd0_err", 96'(rerr), 96'h0);

    // Strobe rises just after an edge; commit lands on the third edge.
    addr_i       = 7'd3;
    write_data_i = 8'h5A;
    write_en_i   = 1'b1;
    tick(2);
    chk("wr3_early", 96'(config_bus_o[31:24]), 96'h00);
    tick(1);
    chk("wr3_lat", 96'(config_bus_o[31:24]), 96'h5A);
    tick(2);
    write_en_i = 1'b0;
    tick(5);
    exp_bus[31:24] = 8'h5A;
    chk("wr3_bus", config_bus_o, exp_bus);

    // Pulse bit held 10 cycles: exactly one cycle high.
    addr_i       = 7'd2;
    write_data_i = 8'h01;
    write_en_i   = 1'b1;
    hi_cnt       = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk_i);
      #1;
      if (config_bus_o[16]) hi_cnt++;
      if (i == 9) write_en_i = 1'b0;
    end
    chk("pulse_hi_cycles", 96'(hi_cnt), 96'd1);
    chk("pulse_bus", config_bus_o, exp_bus);
    do_read("rd2", 7'd2, 1'b0, 8'h00, rdata, rerr);
    chk("pulse_readback", 96'(rdata), 96'h00);

    // Sticky status reg0 bit3.
    status_bus_i = 32'h08;
    tick(1);
    status_bus_i = 32'h00;
    chk("irq_lag", 96'(irq_o), 96'h0);
    tick(1);
    chk("irq_set", 96'(irq_o), 96'h1);
    do_read("rd12", 7'd12, 1'b0, 8'h00, rdata, rerr);
    chk("sticky_read", 96'(rdata), 96'h08);
    do_write(7'd12, 8'h08, errs);
    chk("w1c_err", 96'(errs), 96'd0);
    chk("w1c_irq", 96'(irq_o), 96'h0);
    do_read("rd12b", 7'd12, 1'b0, 8'h00, rdata, rerr);
    chk("w1c_read", 96'(rdata), 96'h00);

    // Live status bit: visible on read, never raises irq.
    status_bus_i = 32'h0000_4000;
    tick(3);
    chk("live_irq", 96'(irq_o), 96'h0);
    do_read("rd13", 7'd13, 1'b0, 8'h00, rdata, rerr);
    chk("live_read", 96'(rdata), 96'h40);
    status_bus_i = 32'h0;

    do_read("rd16", 7'd16, 1'b0, 8'h00, rdata, rerr);
    chk("oor_read_data", 96'(rdata), 96'hFF);
    chk("oor_read_err", 96'(rerr), 96'h1);
    do_write(7'd20, 8'h77, errs);
    chk("oor_write_err", 96'(errs), 96'd1);
    chk("oor_write_bus", config_bus_o, exp_bus);

    // Write and read strobes together: read sees the new value.
    do_read("wr_rd5", 7'd5, 1'b1, 8'h3C, rdata, rerr);
    chk("wr_rd5_data", 96'(rdata), 96'h3C);
    exp_bus[47:40] = 8'h3C;
    chk("wr_rd5_bus", config_bus_o, exp_bus);

    // Reset while the write strobe is still in the synchroniser.
    addr_i       = 7'd4;
    write_data_i = 8'h99;
    write_en_i   = 1'b1;
    tick(1);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(6);
    exp_bus = 96'hCC;
    chk("rst_abort_bus", config_bus_o, exp_bus);
    write_en_i = 1'b0;
    tick(5);
    chk("rst_abort_after", config_bus_o, exp_bus);
    chk("rst_abort_err", 96'(error_o), 96'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
